// File: rtl/mc_pkg.sv
// Shared encodings for the multicycle MIPS controller: states, opcodes, funct codes,
// ALU operations and datapath mux selects, plus the per-state Moore control table.
package mc_pkg;

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB, S_MEMWR,
    S_RTYPEEX, S_RTYPEWB, S_BEQEX, S_ADDIEX, S_ADDIWB, S_JEX
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  localparam logic [2:0] ALU_ADD  = 3'b010;
  localparam logic [2:0] ALU_SUB  = 3'b110;
  localparam logic [2:0] ALU_AND  = 3'b000;
  localparam logic [2:0] ALU_OR   = 3'b001;
  localparam logic [2:0] ALU_SLT  = 3'b111;
  localparam logic [2:0] ALU_IDLE = 3'b000;

  localparam logic [1:0] SRCB_REG   = 2'b00;
  localparam logic [1:0] SRCB_FOUR  = 2'b01;
  localparam logic [1:0] SRCB_IMM   = 2'b10;
  localparam logic [1:0] SRCB_IMMSH = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef enum logic [1:0] {ALUOP_NONE, ALUOP_ADD, ALUOP_SUB, ALUOP_FUNCT} aluop_t;

  typedef struct packed {
    logic       iord;
    logic       memwrite;
    logic       regdst;
    logic       memtoreg;
    logic       regwrite;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [1:0] pcsrc;
    aluop_t     aluop;
  } ctrl_t;

  // Moore outputs of each state; anything not set here stays 0.
  function automatic ctrl_t state_ctrl(state_t s);
    ctrl_t c;
    c = '0;
    case (s)
      S_FETCH:   begin c.alusrcb = SRCB_FOUR;  c.aluop = ALUOP_ADD; end
      S_DECODE:  begin c.alusrcb = SRCB_IMMSH; c.aluop = ALUOP_ADD; end
      S_MEMADR:  begin c.alusrca = 1'b1; c.alusrcb = SRCB_IMM; c.aluop = ALUOP_ADD; end
      S_MEMRD:   c.iord = 1'b1;
      S_MEMWB:   begin c.regwrite = 1'b1; c.memtoreg = 1'b1; end
      S_MEMWR:   begin c.iord = 1'b1; c.memwrite = 1'b1; end
      S_RTYPEEX: begin c.alusrca = 1'b1; c.aluop = ALUOP_FUNCT; end
      S_RTYPEWB: begin c.regwrite = 1'b1; c.regdst = 1'b1; end
      S_BEQEX:   begin c.alusrca = 1'b1; c.aluop = ALUOP_SUB; c.pcsrc = PCSRC_ALUOUT; end
      S_ADDIEX:  begin c.alusrca = 1'b1; c.alusrcb = SRCB_IMM; c.aluop = ALUOP_ADD; end
      S_ADDIWB:  c.regwrite = 1'b1;
      S_JEX:     c.pcsrc = PCSRC_JUMP;
      default:   c = '0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/mc_aludec.sv
// ALU decoder: maps the controller's ALU operation class and the R-type funct field
// to an ALU control code, flagging funct values the ALU does not implement.
module mc_aludec
  import mc_pkg::*;
(
  input  aluop_t      aluop,
  input  logic [5:0]  funct,
  output logic [2:0]  alucontrol,
  output logic        funct_illegal
);

  // NOTE: every output gets a default before the case so no latch is inferred.
  always_comb begin
    alucontrol    = ALU_IDLE;
    funct_illegal = 1'b0;
    case (aluop)
      ALUOP_ADD: alucontrol = ALU_ADD;
      ALUOP_SUB: alucontrol = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct)
          FN_ADD:  alucontrol = ALU_ADD;
          FN_SUB:  alucontrol = ALU_SUB;
          FN_AND:  alucontrol = ALU_AND;
          FN_OR:   alucontrol = ALU_OR;
          FN_SLT:  alucontrol = ALU_SLT;
          default: begin
            alucontrol    = ALU_ADD;
            funct_illegal = 1'b1;
          end
        endcase
      end
      default: alucontrol = ALU_IDLE;
    endcase
  end

endmodule

// File: rtl/mc_controller.sv
// Multicycle MIPS control FSM (lw/sw/R-type/beq/addi/j). Defining MC_CONTROLLER_BNE_EN
// adds bne, executed in BEQEX with the branch condition inverted.
module mc_controller
  import mc_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       memready,
  output logic       pcen,
  output logic       iord,
  output logic       memwrite,
  output logic       irwrite,
  output logic       regdst,
  output logic       memtoreg,
  output logic       regwrite,
  output logic       alusrca,
  output logic [1:0] alusrcb,
  output logic [1:0] pcsrc,
  output logic [2:0] alucontrol,
  output logic       illegal
);

  state_t state;
  state_t state_nxt;
  ctrl_t  ctrl;
  logic   is_bne;
  logic   op_supported;
  logic   funct_illegal;

`ifdef MC_CONTROLLER_BNE_EN
  assign is_bne = (op == OP_BNE);
`else
  assign is_bne = 1'b0;
`endif

  always_comb begin
    case (op)
      OP_LW, OP_SW, OP_RTYPE, OP_BEQ, OP_ADDI, OP_J: op_supported = 1'b1;
      default:                                       op_supported = is_bne;
    endcase
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_FETCH:   if (memready) state_nxt = S_DECODE;
      S_DECODE: begin
        case (op)
          OP_LW, OP_SW: state_nxt = S_MEMADR;
          OP_RTYPE:     state_nxt = S_RTYPEEX;
          OP_BEQ:       state_nxt = S_BEQEX;
          OP_ADDI:      state_nxt = S_ADDIEX;
          OP_J:         state_nxt = S_JEX;
          default:      state_nxt = is_bne ? S_BEQEX : S_FETCH;
        endcase
      end
      S_MEMADR:  state_nxt = (op == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD:   if (memready) state_nxt = S_MEMWB;
      S_MEMWR:   if (memready) state_nxt = S_FETCH;
      S_RTYPEEX: state_nxt = S_RTYPEWB;
      S_ADDIEX:  state_nxt = S_ADDIWB;
      default:   state_nxt = S_FETCH;
    endcase
  end

  // The Moore outputs are registered alongside the state so they leave flops directly.
  // NOTE: sequential state uses non-blocking assignments; the asynchronous reset
  // branch drops write strobes the instant reset rises.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_FETCH;
      ctrl  <= state_ctrl(S_FETCH);
    end else begin
      state <= state_nxt;
      ctrl  <= state_ctrl(state_nxt);
    end
  end

  assign iord     = ctrl.iord;
  assign memwrite = ctrl.memwrite;
  assign regdst   = ctrl.regdst;
  assign memtoreg = ctrl.memtoreg;
  assign regwrite = ctrl.regwrite;
  assign alusrca  = ctrl.alusrca;
  assign alusrcb  = ctrl.alusrcb;
  assign pcsrc    = ctrl.pcsrc;

  mc_aludec u_aludec (
    .aluop         (ctrl.aluop),
    .funct         (funct),
    .alucontrol    (alucontrol),
    .funct_illegal (funct_illegal)
  );

  // Gated enables follow memready/zero within the cycle; reset masks them outright.
  always_comb begin
    pcen    = 1'b0;
    irwrite = 1'b0;
    case (state)
      S_FETCH: begin
        pcen    = memready;
        irwrite = memready;
      end
      S_BEQEX: pcen = is_bne ? ~zero : zero;
      S_JEX:   pcen = 1'b1;
      default: ;
    endcase
    if (reset) begin
      pcen    = 1'b0;
      irwrite = 1'b0;
    end
  end

  assign illegal = ((state == S_DECODE) && !op_supported) ||
                   ((state == S_RTYPEEX) && funct_illegal);

endmodule

// File: tb/tb_mc_controller.sv
// Scoreboard bench for mc_controller: each instruction is expanded into a per-cycle
// plan of inputs and expected outputs; a monitor compares the DUT on falling edges.
module tb_mc_controller;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [5:0] op = '0;
  logic [5:0] funct = '0;
  logic       zero = 1'b0;
  logic       memready = 1'b1;
  logic       pcen, iord, memwrite, irwrite, regdst, memtoreg, regwrite, alusrca;
  logic [1:0] alusrcb, pcsrc;
  logic [2:0] alucontrol;
  logic       illegal;

  typedef struct packed {
    logic       pcen, iord, memwrite, irwrite, regdst, memtoreg, regwrite, alusrca;
    logic [1:0] alusrcb, pcsrc;
    logic [2:0] aluc;
    logic       illegal;
  } vec_t;

  typedef struct {
    logic mr;
    logic z;
    vec_t exp;
  } cyc_t;

  typedef struct {
    vec_t       v;
    logic [5:0] op;
  } sb_item_t;

  cyc_t     plan[$];
  sb_item_t sb[$];
  int       tests = 0;
  int       fails = 0;
  vec_t     act;

  always #5 clk = ~clk;

  mc_controller dut (
    .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero), .memready(memready),
    .pcen(pcen), .iord(iord), .memwrite(memwrite), .irwrite(irwrite), .regdst(regdst),
    .memtoreg(memtoreg), .regwrite(regwrite), .alusrca(alusrca), .alusrcb(alusrcb),
    .pcsrc(pcsrc), .alucontrol(alucontrol), .illegal(illegal)
  );

  assign act = '{pcen, iord, memwrite, irwrite, regdst, memtoreg, regwrite, alusrca,
                 alusrcb, pcsrc, alucontrol, illegal};

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    tests++;
    if (actual !== expected) begin
      fails++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, actual, expected, $time);
    end
  endtask

  function automatic vec_t base(input logic [1:0] srcb, input logic [2:0] aluc);
    vec_t v;
    v = '0;
    v.alusrcb = srcb;
    v.aluc    = aluc;
    return v;
  endfunction

  function automatic logic bne_enabled();
`ifdef MC_CONTROLLER_BNE_EN
    return 1'b1;
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic legal_op(input logic [5:0] o);
    return (o == 6'b100011) || (o == 6'b101011) || (o == 6'b000000) || (o == 6'b000100) ||
           (o == 6'b001000) || (o == 6'b000010) || (o == 6'b000101 && bne_enabled());
  endfunction

  function automatic logic [3:0] alu_of_funct(input logic [5:0] f);
    // {illegal, alucontrol}
    case (f)
      6'b100000: return 4'b0_010;
      6'b100010: return 4'b0_110;
      6'b100100: return 4'b0_000;
      6'b100101: return 4'b0_001;
      6'b101010: return 4'b0_111;
      default:   return 4'b1_010;
    endcase
  endfunction

  task automatic add(input logic mr, input logic z, input vec_t v);
    cyc_t c;
    c.mr = mr; c.z = z; c.exp = v;
    plan.push_back(c);
  endtask

  function automatic logic rb();
    return 1'($urandom_range(0, 1));
  endfunction

  // Cycle-by-cycle behaviour of one instruction: fw fetch stalls, mw memory stalls.
  task automatic expand(input logic [5:0] o, input logic [5:0] f, input int fw, input int mw,
                        input logic z);
    vec_t       v;
    logic [3:0] a;
    for (int i = 0; i < fw; i++) add(1'b0, rb(), base(2'b01, 3'b010));
    v = base(2'b01, 3'b010); v.pcen = 1'b1; v.irwrite = 1'b1;
    add(1'b1, rb(), v);
    v = base(2'b11, 3'b010); v.illegal = !legal_op(o);
    add(rb(), rb(), v);
    if (o == 6'b100011 || o == 6'b101011) begin
      v = base(2'b10, 3'b010); v.alusrca = 1'b1;
      add(rb(), rb(), v);
      v = '0; v.iord = 1'b1; v.memwrite = (o == 6'b101011);
      for (int i = 0; i < mw; i++) add(1'b0, rb(), v);
      add(1'b1, rb(), v);
      if (o == 6'b100011) begin
        v = '0; v.regwrite = 1'b1; v.memtoreg = 1'b1;
        add(rb(), rb(), v);
      end
    end else if (o == 6'b000000) begin
      a = alu_of_funct(f);
      v = base(2'b00, a[2:0]); v.alusrca = 1'b1; v.illegal = a[3];
      add(rb(), rb(), v);
      v = '0; v.regwrite = 1'b1; v.regdst = 1'b1;
      add(rb(), rb(), v);
    end else if (o == 6'b000100 || (o == 6'b000101 && bne_enabled())) begin
      v = base(2'b00, 3'b110); v.alusrca = 1'b1; v.pcsrc = 2'b01;
      v.pcen = (o == 6'b000101) ? ~z : z;
      add(rb(), z, v);
    end else if (o == 6'b001000) begin
      v = base(2'b10, 3'b010); v.alusrca = 1'b1;
      add(rb(), rb(), v);
      v = '0; v.regwrite = 1'b1;
      add(rb(), rb(), v);
    end else if (o == 6'b000010) begin
      v = '0; v.pcsrc = 2'b10; v.pcen = 1'b1;
      add(rb(), rb(), v);
    end
  endtask

  task automatic push_exp(input vec_t v);
    sb_item_t it;
    it.v = v; it.op = op;
    sb.push_back(it);
  endtask

  task automatic run_plan(input logic [5:0] o, input logic [5:0] f);
    cyc_t c;
    while (plan.size() > 0) begin
      c = plan.pop_front();
      @(posedge clk);
      #1;
      op = o; funct = f; memready = c.mr; zero = c.z;
      push_exp(c.exp);
    end
  endtask

  task automatic do_instr(input logic [5:0] o, input logic [5:0] f, input int fw, input int mw,
                          input logic z);
    expand(o, f, fw, mw, z);
    run_plan(o, f);
  endtask

  // Monitor: one scoreboard entry is consumed per cycle, compared mid-cycle.
  initial begin
    sb_item_t it;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        it = sb.pop_front();
        check($sformatf("outputs op=%b", it.op), 32'(act), 32'(it.v));
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [5:0] ops[8];
    logic [5:0] fns[6];
    logic [5:0] o, f;
    ops = '{6'b100011, 6'b101011, 6'b000000, 6'b000100, 6'b000101, 6'b001000, 6'b000010, 6'b111111};
    fns = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010, 6'b000000};

    // Reset held with memready high: enables must stay masked.
    repeat (2) begin
      @(posedge clk); #1;
      push_exp(base(2'b01, 3'b010));
    end
    @(posedge clk); #1;
    reset = 1'b0; memready = 1'b0;
    push_exp(base(2'b01, 3'b010));

    do_instr(6'b100011, 6'b000000, 0, 0, 1'b0);   // lw, no stalls: 5 cycles
    do_instr(6'b101011, 6'b000000, 1, 3, 1'b0);   // sw, memwrite held 4 cycles
    do_instr(6'b000100, 6'b000000, 0, 0, 1'b1);   // beq taken
    do_instr(6'b000100, 6'b000000, 0, 0, 1'b0);   // beq not taken
    do_instr(6'b000000, 6'b101010, 0, 0, 1'b0);   // slt
    do_instr(6'b000000, 6'b111111, 0, 0, 1'b0);   // bad funct
    do_instr(6'b000101, 6'b000000, 0, 0, 1'b0);   // bne (or illegal)
    do_instr(6'b111111, 6'b000000, 0, 0, 1'b0);   // unsupported opcode
    do_instr(6'b001000, 6'b000000, 2, 0, 1'b0);   // addi
    do_instr(6'b000010, 6'b000000, 0, 0, 1'b0);   // j

    // Asynchronous reset while sw is stalled in the write state.
    expand(6'b101011, 6'b000000, 0, 1, 1'b0);
    void'(plan.pop_back());
    run_plan(6'b101011, 6'b000000);
    @(posedge clk); #1;
    memready = 1'b0;
    check("memwrite_before_reset", 32'(memwrite), 32'd1);
    #1 reset = 1'b1;
    #1;
    check("memwrite_async_drop", 32'(memwrite), 32'd0);
    check("iord_async_drop", 32'(iord), 32'd0);
    check("alusrcb_async_fetch", 32'(alusrcb), 32'd1);
    push_exp(base(2'b01, 3'b010));
    @(posedge clk); #1;
    reset = 1'b0;
    push_exp(base(2'b01, 3'b010));
    do_instr(6'b100011, 6'b000000, 0, 1, 1'b0);   // next instruction starts from FETCH

    for (int n = 0; n < 300; n++) begin
      o = ops[$urandom_range(0, 7)];
      if ($urandom_range(0, 7) == 0) o = 6'($urandom);
      f = fns[$urandom_range(0, 5)];
      if (f == 6'b000000) f = 6'($urandom);
      do_instr(o, f, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), rb());
    end

    @(posedge clk); #6;
    check("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
